// File: rtl/ysyx_22041412_icache_nway.sv
// N-way set-associative instruction cache: register-array storage, round-robin
// replacement once a set is full, AXI burst refill and a single-cycle fence.i flush.
module ysyx_22041412_icache_nway #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_BEATS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                cpu_req_addr,
  input  logic                       cpu_valid,
  input  logic                       cpu_abort,
  output logic                       cpu_ready,
  output logic [64*LINE_BEATS-1:0]   cpu_read_data,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic                       axi_valid_o,
  output logic [31:0]                axi_r_addr_o,
  output logic [7:0]                 axi_r_len_o,
  input  logic                       axi_ready_i,
  input  logic [63:0]                axi_r_data_i,
  input  logic                       axi_r_last_i,
  output logic [63:0]                cache_hit,
  output logic [63:0]                cache_miss
);

  localparam int unsigned LINE_W = 64 * LINE_BEATS;
  localparam int unsigned OFF_W  = $clog2(LINE_BEATS * 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned BEAT_W = $clog2(LINE_BEATS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [BEAT_W-1:0] beat_q;
  logic [LINE_W-1:0] line_q;
  logic [WAY_W-1:0]  victim_q;
  logic              victim_rr_q;
  logic              abort_seen_q;
  logic              flush_pend_q;

  logic              cpu_ready_q;
  logic [LINE_W-1:0] rdata_q;
  logic              flush_done_q;
  logic              axi_valid_q;
  logic [31:0]       axi_addr_q;
  logic [7:0]        axi_len_q;
  logic [63:0]       hit_cnt_q;
  logic [63:0]       miss_cnt_q;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [LINE_W-1:0] hit_data;
  logic [LINE_W-1:0] line_fill;
  logic              beat_fire;
  logic              last_fire;
  logic              unused_offset;

  assign unused_offset = ^cpu_req_addr[OFF_W-1:0];

  assign cpu_ready     = cpu_ready_q;
  assign cpu_read_data = rdata_q;
  assign flush_done    = flush_done_q;
  assign axi_valid_o   = axi_valid_q;
  assign axi_r_addr_o  = axi_addr_q;
  assign axi_r_len_o   = axi_len_q;
  assign cache_hit     = hit_cnt_q;
  assign cache_miss    = miss_cnt_q;

  // Tags are unique within a set because only misses install lines.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx_q] && (tag_q[w][req_idx_q] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][req_idx_q] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign hit_data  = data_q[hit_way][req_idx_q];
  assign beat_fire = (state_q == S_REFILL) && axi_ready_i;
  assign last_fire = beat_fire && axi_r_last_i;

  always_comb begin
    line_fill = line_q;
    line_fill[{beat_q, 6'b0} +: 64] = axi_r_data_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (flush_req || flush_pend_q) state_d = S_FLUSH;
        else if (cpu_valid)            state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (cpu_abort) state_d = S_IDLE;
        else if (hit)  state_d = S_RESP;
        else           state_d = S_REFILL;
      end
      S_REFILL: begin
        if (last_fire) state_d = (abort_seen_q || cpu_abort) ? S_IDLE : S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
      beat_q       <= '0;
      victim_q     <= '0;
      victim_rr_q  <= 1'b0;
      abort_seen_q <= 1'b0;
      flush_pend_q <= 1'b0;
      cpu_ready_q  <= 1'b0;
      rdata_q      <= '0;
      flush_done_q <= 1'b0;
      axi_valid_q  <= 1'b0;
      axi_addr_q   <= '0;
      axi_len_q    <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cpu_ready_q  <= (state_q == S_RESP);
      flush_done_q <= (state_q == S_FLUSH);

      if (state_q == S_FLUSH)                    flush_pend_q <= 1'b0;
      else if (flush_req && state_q != S_IDLE)   flush_pend_q <= 1'b1;

      if (state_q == S_IDLE && cpu_valid) begin
        req_tag_q <= cpu_req_addr[31 -: TAG_W];
        req_idx_q <= cpu_req_addr[OFF_W +: IDX_W];
      end

      if (state_q == S_LOOKUP) begin
        if (hit) begin
          hit_cnt_q <= hit_cnt_q + 64'd1;
          if (!cpu_abort) rdata_q <= hit_data;
        end else begin
          miss_cnt_q <= miss_cnt_q + 64'd1;
          if (!cpu_abort) begin
            axi_valid_q  <= 1'b1;
            axi_addr_q   <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            axi_len_q    <= 8'(LINE_BEATS - 1);
            victim_q     <= inv_found ? inv_way : rr_q[req_idx_q];
            victim_rr_q  <= !inv_found;
            abort_seen_q <= 1'b0;
            beat_q       <= '0;
          end
        end
      end

      if (state_q == S_REFILL) begin
        if (cpu_abort) abort_seen_q <= 1'b1;
        if (beat_fire) beat_q <= axi_r_last_i ? '0 : beat_q + BEAT_W'(1);
        if (last_fire) begin
          axi_valid_q <= 1'b0;
          valid_q[victim_q][req_idx_q] <= 1'b1;
          if (victim_rr_q) rr_q[req_idx_q] <= rr_q[req_idx_q] + WAY_W'(1);
          // An aborted refill still installs, but the CPU-visible line is left untouched.
          if (!(abort_seen_q || cpu_abort)) rdata_q <= line_fill;
        end
      end

      if (state_q == S_FLUSH) begin
        for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
        for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) line_q <= line_fill;
    if (last_fire) begin
      tag_q[victim_q][req_idx_q]  <= req_tag_q;
      data_q[victim_q][req_idx_q] <= line_fill;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_icache_nway.sv
// Directed bench for the n-way icache: scoreboard of expected lines, AXI beats
// served inline, immediate assertions at every check point.
module tb_ysyx_22041412_icache_nway;

  localparam int unsigned LB = 2;
  localparam int unsigned LW = 64 * LB;

  logic          clk;
  logic          rst_n;
  logic [31:0]   cpu_req_addr;
  logic          cpu_valid;
  logic          cpu_abort;
  logic          cpu_ready;
  logic [LW-1:0] cpu_read_data;
  logic          flush_req;
  logic          flush_done;
  logic          axi_valid_o;
  logic [31:0]   axi_r_addr_o;
  logic [7:0]    axi_r_len_o;
  logic          axi_ready_i;
  logic [63:0]   axi_r_data_i;
  logic          axi_r_last_i;
  logic [63:0]   cache_hit;
  logic [63:0]   cache_miss;

  ysyx_22041412_icache_nway #(.WAYS(4), .SETS(64), .LINE_BEATS(LB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(cpu_req_addr), .cpu_valid(cpu_valid), .cpu_abort(cpu_abort),
    .cpu_ready(cpu_ready), .cpu_read_data(cpu_read_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .axi_valid_o(axi_valid_o), .axi_r_addr_o(axi_r_addr_o), .axi_r_len_o(axi_r_len_o),
    .axi_ready_i(axi_ready_i), .axi_r_data_i(axi_r_data_i), .axi_r_last_i(axi_r_last_i),
    .cache_hit(cache_hit), .cache_miss(cache_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  logic [LW-1:0] exp_q[$];
  logic [63:0]   exp_hit  = '0;
  logic [63:0]   exp_miss = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_val(input logic [31:0] la, input int unsigned k);
    if (la == 32'h8000_0010) return (k == 0) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222;
    return {la, 32'hC0DE_0000 | 32'(k)};
  endfunction

  function automatic logic [LW-1:0] line_val(input logic [31:0] la);
    return {beat_val(la, 1), beat_val(la, 0)};
  endfunction

  task automatic serve_burst(input logic [31:0] la, input bit abort_first, input bit flush_first);
    for (int k = 0; k < LB; k++) begin
      axi_ready_i  = 1'b1;
      axi_r_data_i = beat_val(la, k);
      axi_r_last_i = (k == LB - 1);
      cpu_abort    = abort_first && (k == 0);
      flush_req    = flush_first && (k == 0);
      step();
    end
    axi_ready_i  = 1'b0;
    axi_r_last_i = 1'b0;
    axi_r_data_i = '0;
    cpu_abort    = 1'b0;
    flush_req    = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input bit hit_b, input bit flush_mid, input string tag);
    logic [31:0]   la;
    logic [LW-1:0] want;
    int            n;
    la = {a[31:4], 4'h0};
    exp_q.push_back(line_val(la));
    cpu_req_addr = a;
    cpu_valid    = 1'b1;
    step();
    cpu_valid = 1'b0;
    step();
    if (hit_b) begin
      exp_hit++;
      chk({tag, ".axi_idle"}, axi_valid_o, 0);
    end else begin
      exp_miss++;
      chk({tag, ".axi_valid"}, axi_valid_o, 1);
      chk({tag, ".axi_addr"}, axi_r_addr_o, la);
      chk({tag, ".axi_len"}, axi_r_len_o, LB - 1);
      serve_burst(la, 1'b0, flush_mid);
      chk({tag, ".axi_drop"}, axi_valid_o, 0);
    end
    n = 0;
    step();
    while (!cpu_ready && n < 8) begin
      step();
      n++;
    end
    chk({tag, ".ready"}, cpu_ready, 1);
    if (hit_b) chk({tag, ".latency"}, n, 0);
    want = exp_q.pop_front();
    chk({tag, ".data"}, cpu_read_data, want);
    chk({tag, ".hits"}, cache_hit, exp_hit);
    chk({tag, ".misses"}, cache_miss, exp_miss);
    step();
    chk({tag, ".ready_pulse"}, cpu_ready, 0);
  endtask

  initial begin
    bit saw;
    int n;
    rst_n = 1'b0; cpu_req_addr = '0; cpu_valid = 1'b0; cpu_abort = 1'b0;
    flush_req = 1'b0; axi_ready_i = 1'b0; axi_r_data_i = '0; axi_r_last_i = 1'b0;
    step(); step();
    chk("rst.ready", cpu_ready, 0);
    chk("rst.axi_valid", axi_valid_o, 0);
    chk("rst.data", cpu_read_data, 0);
    chk("rst.hits", cache_hit, 0);
    chk("rst.misses", cache_miss, 0);
    rst_n = 1'b1;
    step();

    // Cold miss, then hit.
    fetch(32'h8000_0010, 1'b0, 1'b0, "cold");
    chk("cold.literal", cpu_read_data, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    fetch(32'h8000_0010, 1'b1, 1'b0, "rehit");

    // Fill set 1, then overflow it and walk the round-robin pointer.
    fetch(32'h8000_0410, 1'b0, 1'b0, "fill1");
    fetch(32'h8000_0810, 1'b0, 1'b0, "fill2");
    fetch(32'h8000_0C10, 1'b0, 1'b0, "fill3");
    fetch(32'h8000_1010, 1'b0, 1'b0, "evict0");
    fetch(32'h8000_0414, 1'b1, 1'b0, "keep1");
    fetch(32'h8000_0810, 1'b1, 1'b0, "keep2");
    fetch(32'h8000_0C1C, 1'b1, 1'b0, "keep3");
    fetch(32'h8000_1010, 1'b1, 1'b0, "keep4");
    fetch(32'h8000_0010, 1'b0, 1'b0, "evicted0");
    fetch(32'h8000_0410, 1'b0, 1'b0, "evicted1");
    fetch(32'h8000_0010, 1'b1, 1'b0, "rr_hit");

    // Abort in LOOKUP: on a hit, then on a miss (no AXI request).
    cpu_req_addr = 32'h8000_0010; cpu_valid = 1'b1; step(); cpu_valid = 1'b0;
    cpu_abort = 1'b1; step(); cpu_abort = 1'b0;
    exp_hit++;
    cpu_req_addr = 32'h8000_2020; cpu_valid = 1'b1; step(); cpu_valid = 1'b0;
    cpu_abort = 1'b1; step(); cpu_abort = 1'b0;
    exp_miss++;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw |= cpu_ready | axi_valid_o;
      step();
    end
    chk("lkabort.quiet", saw, 0);
    chk("lkabort.hits", cache_hit, exp_hit);
    chk("lkabort.misses", cache_miss, exp_miss);
    fetch(32'h8000_2020, 1'b0, 1'b0, "lkabort.refetch");

    // Abort during refill: burst still consumed and line installed.
    cpu_req_addr = 32'h8000_3030; cpu_valid = 1'b1; step(); cpu_valid = 1'b0;
    step();
    exp_miss++;
    chk("rfabort.axi_valid", axi_valid_o, 1);
    serve_burst(32'h8000_3030, 1'b1, 1'b0);
    chk("rfabort.axi_drop", axi_valid_o, 0);
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw |= cpu_ready;
      step();
    end
    chk("rfabort.no_ready", saw, 0);
    fetch(32'h8000_3030, 1'b1, 1'b0, "rfabort.hit");

    // Flush arriving mid-refill is serviced after RESP.
    fetch(32'h8000_4040, 1'b0, 1'b1, "flush.fill");
    n = 0;
    while (!flush_done && n < 8) begin
      step();
      n++;
    end
    chk("flush.done", flush_done, 1);
    step();
    chk("flush.pulse", flush_done, 0);
    fetch(32'h8000_0010, 1'b0, 1'b0, "flush.miss0");
    fetch(32'h8000_3030, 1'b0, 1'b0, "flush.miss1");

    // Asynchronous reset between beats.
    cpu_req_addr = 32'h8000_5050; cpu_valid = 1'b1; step(); cpu_valid = 1'b0;
    step();
    axi_ready_i = 1'b1; axi_r_data_i = beat_val(32'h8000_5050, 0); axi_r_last_i = 1'b0;
    step();
    axi_ready_i = 1'b0; axi_r_data_i = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.ready", cpu_ready, 0);
    chk("arst.axi_valid", axi_valid_o, 0);
    chk("arst.axi_addr", axi_r_addr_o, 0);
    chk("arst.axi_len", axi_r_len_o, 0);
    chk("arst.flush_done", flush_done, 0);
    chk("arst.data", cpu_read_data, 0);
    chk("arst.hits", cache_hit, 0);
    chk("arst.misses", cache_miss, 0);
    step();
    rst_n = 1'b1;
    exp_hit = '0;
    exp_miss = '0;
    step();
    fetch(32'h8000_0010, 1'b0, 1'b0, "arst.miss0");
    fetch(32'h8000_0810, 1'b0, 1'b0, "arst.miss1");

    chk("sb.empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
